// File: rtl/count_sequencer.sv
// ============================================================================
// Module   : count_sequencer
// Brief    : Drives direction/enable for an external up/down counter so that
//            it runs from its current value to a target, optionally ping-ponging
//            between the two endpoints. Ping-pong is built with
//            COUNT_SEQ_PINGPONG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             dir_req,
    input  logic [WIDTH-1:0] target,
    input  logic [2:0]       laps,
    input  logic             pingpong,
    input  logic [WIDTH-1:0] count,
    output logic             Y,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [2:0]       lap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TURN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_y;
    logic [WIDTH-1:0] r_tgt;
    logic             w_at_tgt;
    logic             w_accept;
    logic             w_turn_exit;
    logic             w_more;

    assign w_at_tgt    = (count == r_tgt);
    assign w_accept    = (r_state == S_IDLE) && start && !abort;
    assign w_turn_exit = (r_state == S_TURN) && !abort;

`ifdef COUNT_SEQ_PINGPONG_EN
    logic [WIDTH-1:0] r_origin;
    logic [2:0]       r_laps_left;
    logic             r_pp;
    logic [2:0]       r_lap_cnt;

    assign w_more  = r_pp && (r_laps_left != 3'd0);
    assign lap_cnt = r_lap_cnt;

    // Each reversal swaps the endpoints, so the next leg returns to where the last began.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_origin    <= '0;
            r_laps_left <= 3'd0;
            r_pp        <= 1'b0;
            r_lap_cnt   <= 3'd0;
        end else if (w_accept) begin
            r_origin    <= count;
            r_laps_left <= laps;
            r_pp        <= pingpong;
            r_lap_cnt   <= 3'd0;
        end else if (w_turn_exit) begin
            r_origin    <= r_tgt;
            r_laps_left <= r_laps_left - 3'd1;
            r_lap_cnt   <= r_lap_cnt + 3'd1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{pingpong, laps};
    assign w_more       = 1'b0;
    assign lap_cnt      = 3'd0;
`endif

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = S_RUN;
                S_RUN:  if (w_at_tgt) w_next = w_more ? S_TURN : S_DONE;
                S_TURN: w_next = S_RUN;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_y     <= 1'b0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_tgt <= target;
                r_y   <= dir_req;
            end else if (w_turn_exit) begin
                r_y   <= ~r_y;
`ifdef COUNT_SEQ_PINGPONG_EN
                r_tgt <= r_origin;
`endif
            end
        end
    end

    // Gated by reset so the counter cannot move before the state register settles.
    assign cnt_en = reset && (r_state == S_RUN) && !w_at_tgt;
    assign busy   = (r_state == S_RUN) || (r_state == S_TURN);
    assign done   = (r_state == S_DONE);
    assign Y      = r_y;

endmodule

`default_nettype wire

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a behavioural counter plus a scoreboard of
// expected (count, direction) advances and expected lap counts at done.
`default_nettype none

module tb_count_sequencer;

    localparam int WIDTH = 4;
    localparam logic [WIDTH-1:0] ONE = 1;
`ifdef COUNT_SEQ_PINGPONG_EN
    localparam bit PP_EN = 1'b1;
`else
    localparam bit PP_EN = 1'b0;
`endif

    logic             clock    = 1'b0;
    logic             reset    = 1'b0;
    logic             start    = 1'b0;
    logic             abort    = 1'b0;
    logic             dir_req  = 1'b0;
    logic             pingpong = 1'b0;
    logic [2:0]       laps     = 3'd0;
    logic [WIDTH-1:0] target   = '0;
    logic [WIDTH-1:0] count    = '0;
    logic [WIDTH-1:0] load_val = '0;
    logic             load     = 1'b0;
    logic             Y, cnt_en, busy, done;
    logic [2:0]       lap_cnt;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] exp_q[$];
    logic [2:0]     done_q[$];
    logic [WIDTH:0] e;
    logic [2:0]     el;

    always #5 clock = ~clock;

    count_sequencer #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .dir_req(dir_req), .target(target), .laps(laps), .pingpong(pingpong),
        .count(count), .Y(Y), .cnt_en(cnt_en), .busy(busy), .done(done),
        .lap_cnt(lap_cnt)
    );

    always @(posedge clock) begin
        if (load)        count <= load_val;
        else if (cnt_en) count <= Y ? count + ONE : count - ONE;
    end

    always @(negedge clock) begin
        if (cnt_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL advance: got advance at count=%0d Y=%b, required no advance", count, Y);
            end else begin
                e = exp_q.pop_front();
                if ({count, Y} !== e) begin
                    errors++;
                    $display("FAIL advance: got count=%0d Y=%b, required count=%0d Y=%b",
                             count, Y, e[WIDTH:1], e[0]);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_pulse: got done=1, required no done");
            end else begin
                el = done_q.pop_front();
                if (lap_cnt !== el) begin
                    errors++;
                    $display("FAIL done_laps: got lap_cnt=%0d, required %0d", lap_cnt, el);
                end
            end
        end
    end

    task automatic sb_push(input logic [WIDTH-1:0] c0, input logic d, input logic [WIDTH-1:0] t,
                           input logic pp, input logic [2:0] lp,
                           output int n, output logic [WIDTH-1:0] fin, output logic [2:0] turns);
        logic [WIDTH-1:0] cur, dst, org, tmp;
        logic dd;
        int left;
        cur = c0; dst = t; org = c0; dd = d; left = int'(lp); turns = 3'd0; n = 0;
        for (int leg = 0; leg < 9; leg++) begin
            while (cur != dst) begin
                exp_q.push_back({cur, dd});
                cur = dd ? cur + ONE : cur - ONE;
                n++;
            end
            n++;
            if (!(pp && PP_EN && left > 0)) break;
            n++;
            tmp = dst; dst = org; org = tmp; dd = ~dd; left--; turns = turns + 3'd1;
        end
        fin = cur;
        done_q.push_back(turns);
    endtask

    task automatic load_count(input logic [WIDTH-1:0] v);
        @(posedge clock); #1 load = 1'b1; load_val = v;
        @(posedge clock); #1 load = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic [WIDTH-1:0] c0, input logic d,
                             input logic [WIDTH-1:0] t, input logic pp, input logic [2:0] lp,
                             input bit poke);
        int exp_n, n;
        logic [WIDTH-1:0] fin;
        logic [2:0] turns;
        load_count(c0);
        sb_push(c0, d, t, pp, lp, exp_n, fin, turns);
        start = 1'b1; dir_req = d; target = t; pingpong = pp; laps = lp;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        checks++;
        if (Y !== d || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: got Y=%b busy=%b, required Y=%b busy=1", nm, Y, busy, d);
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clock); n++; #1;
            if (poke && n == 1) begin
                start = 1'b1; target = t ^ 4'b0011; dir_req = ~d;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s_latency: got done after %0d edges, required %0d", nm, n, exp_n);
        end
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: got done=%b busy=%b, required 0 0", nm, done, busy);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || cnt_en !== 1'b0 || count !== fin || lap_cnt !== turns ||
            exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b cnt_en=%b count=%0d lap_cnt=%0d pending=%0d/%0d, required 0 0 %0d %0d 0/0",
                     nm, busy, cnt_en, count, lap_cnt, exp_q.size(), done_q.size(), fin, turns);
        end
        exp_q.delete(); done_q.delete();
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (Y !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lap_cnt !== 3'd0 || cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got Y=%b busy=%b done=%b lap_cnt=%0d cnt_en=%b, required all 0",
                     Y, busy, done, lap_cnt, cnt_en);
        end
        @(posedge clock); #1 reset = 1'b1;
    endtask

    task automatic test_abort;
        load_count(4'd0);
        start = 1'b1; dir_req = 1'b1; target = 4'd9; pingpong = 1'b0; laps = 3'd0;
        exp_q.push_back({4'd0, 1'b1});
        exp_q.push_back({4'd1, 1'b1});
        exp_q.push_back({4'd2, 1'b1});
        @(posedge clock); #1 start = 1'b0;
        @(posedge clock);
        @(posedge clock); #1 abort = 1'b1;
        @(posedge clock); #1 abort = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || cnt_en !== 1'b0 || count !== 4'd3) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b cnt_en=%b count=%0d, required 0 0 3", busy, cnt_en, count);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: got done=%b busy=%b, required 0 0", done, busy);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_steps: got %0d advances missing, required 0", exp_q.size());
        end
        exp_q.delete();
        run_check("after_abort", 4'd3, 1'b0, 4'd1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_check("same_target", 4'd7, 1'b1, 4'd7, 1'b0, 3'd0, 1'b1);
        run_check("busy_start", 4'd0, 1'b1, 4'd5, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        load_count(4'd0);
        start = 1'b1; dir_req = 1'b1; target = 4'd9;
        exp_q.push_back({4'd0, 1'b1});
        exp_q.push_back({4'd1, 1'b1});
        @(posedge clock); #1 start = 1'b0;
        @(posedge clock);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt_en: got cnt_en=%b, required 0", cnt_en);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Y !== 1'b0 || lap_cnt !== 3'd0 ||
            count !== 4'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b Y=%b lap_cnt=%0d count=%0d pending=%0d, required 0 0 0 0 2 0",
                     busy, done, Y, lap_cnt, count, exp_q.size());
        end
        exp_q.delete();
        @(posedge clock); #1 reset = 1'b1;
        run_check("after_reset", 4'd2, 1'b1, 4'd4, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        test_reset;
        run_check("up_run", 4'd0, 1'b1, 4'd5, 1'b0, 3'd0, 1'b0);
        run_check("down_wrap", 4'd2, 1'b0, 4'd14, 1'b0, 3'd0, 1'b0);
        run_check("pingpong", 4'd3, 1'b1, 4'd6, 1'b1, 3'd2, 1'b0);
        run_check("pp_odd", 4'd10, 1'b0, 4'd8, 1'b1, 3'd1, 1'b0);
        run_check("laps_no_pp", 4'd1, 1'b0, 4'd15, 1'b0, 3'd3, 1'b0);
        test_abort;
        test_back_to_back;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
